// File: rtl/wl_csr_reqrsp.sv
// Accelerator CSR slave on reqrsp: SCRATCH/CTRL/STATUS/CYCLES, start/done handshake, level irq.
// One-cycle response latency; q_ready drops only while a held response waits on p_ready.
package wl_csr_reqrsp_pkg;
    typedef enum logic [3:0] {
        AMONone = 4'h0, AMOSwap = 4'h1, AMOAdd  = 4'h2, AMOAnd = 4'h3,
        AMOOr   = 4'h4, AMOXor  = 4'h5, AMOMax  = 4'h6, AMOMaxu = 4'h7,
        AMOMin  = 4'h8, AMOMinu = 4'h9, AMOLR   = 4'hA, AMOSC  = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } core_data_req_chan_t;

    typedef struct packed {
        core_data_req_chan_t q;
        logic                q_valid;
        logic                p_ready;
    } core_data_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } core_data_rsp_chan_t;

    typedef struct packed {
        core_data_rsp_chan_t p;
        logic                p_valid;
        logic                q_ready;
    } core_data_rsp_t;
endpackage

module wl_csr_reqrsp
    import wl_csr_reqrsp_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = 32'h0004_0000,
    parameter type                  req_t     = core_data_req_t,
    parameter type                  rsp_t     = core_data_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i,
    output rsp_t rsp_o,
    output logic start_o,
    input  logic done_i,
    output logic busy_o,
    output logic irq_o
);
    logic                 p_valid;
    logic [DataWidth-1:0] p_data;
    logic                 p_error;
    logic [DataWidth-1:0] scratch;
    logic [31:0]          cycles;
    logic                 irq_en;
    logic                 busy;
    logic                 done;
    logic                 start_q;

    logic                 q_ready;
    logic                 accept;
    logic                 hit;
    logic                 err;
    logic                 wr_ok;
    logic [1:0]           idx;
    logic                 done_evt;
    logic                 start_evt;
    logic                 w1c;
    logic [DataWidth-1:0] rdata;
    logic                 unused_bits;

    assign idx       = req_i.q.addr[3:2];
    assign hit       = (req_i.q.addr[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]);
    assign err       = !hit || (req_i.q.amo != AMONone);
    assign q_ready   = !p_valid || req_i.p_ready;
    assign accept    = req_i.q_valid && q_ready;
    assign wr_ok     = accept && req_i.q.write && !err;
    assign done_evt  = done_i && busy;
    // START is judged against BUSY before this edge, so a start racing done_i is dropped.
    assign start_evt = wr_ok && (idx == 2'd1) && req_i.q.strb[0] && req_i.q.data[0] && !busy;
    assign w1c       = wr_ok && (idx == 2'd2) && req_i.q.strb[0] && req_i.q.data[1];
    assign unused_bits = ^{req_i.q.size, req_i.q.addr[1:0]};

    always_comb begin
        rdata = '0;
        unique case (idx)
            2'd0: rdata = scratch;
            2'd1: rdata = {{(DataWidth-2){1'b0}}, irq_en, 1'b0};
            2'd2: rdata = {{(DataWidth-2){1'b0}}, done, busy};
            2'd3: rdata = cycles;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_valid <= 1'b0;
            p_data  <= '0;
            p_error <= 1'b0;
            scratch <= '0;
            cycles  <= '0;
            irq_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            if (accept) begin
                p_valid <= 1'b1;
                p_data  <= (err || req_i.q.write) ? '0 : rdata;
                p_error <= err;
            end else if (req_i.p_ready) begin
                p_valid <= 1'b0;
            end

            if (wr_ok && idx == 2'd0) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_i.q.strb[b]) scratch[8*b +: 8] <= req_i.q.data[8*b +: 8];
                end
            end
            if (wr_ok && idx == 2'd1 && req_i.q.strb[0]) irq_en <= req_i.q.data[1];

            start_q <= start_evt;
            if (start_evt)     cycles <= '0;
            else if (busy)     cycles <= cycles + 32'd1;

            if (start_evt)     busy <= 1'b1;
            else if (done_evt) busy <= 1'b0;

            // A completion landing with a W1C keeps DONE set so the event is not lost.
            if (done_evt)      done <= 1'b1;
            else if (w1c)      done <= 1'b0;
        end
    end

    always_comb begin
        rsp_o         = '0;
        rsp_o.p.data  = p_data;
        rsp_o.p.error = p_error;
        rsp_o.p_valid = p_valid;
        rsp_o.q_ready = q_ready;
    end

    assign start_o = start_q;
    assign busy_o  = busy;
    assign irq_o   = done & irq_en;
endmodule

// File: doc/wl_csr_reqrsp.md
WL_CSR_REQRSP -- requirements
Module: wl_csr_reqrsp

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, bus address width.
REQ-002 SHALL have parameter DataWidth, default 32, bus data width (only 32 supported).
REQ-003 SHALL have parameter BaseAddr, default 32'h0004_0000, base of the 16-byte CSR window.
REQ-004 SHALL have type parameters req_t / rsp_t, default core_data_req_t / core_data_rsp_t, reqrsp request/response structs.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  req_t  reqrsp request: q (addr, write, amo, data, strb, size), q_valid, p_ready.
REQ-008 SHALL have port rsp_o  output  rsp_t  reqrsp response: p (data, error), p_valid, q_ready.
REQ-009 SHALL have port start_o  output  1  one-cycle start pulse to accelerator.
REQ-010 SHALL have port done_i  input  1  one-cycle completion pulse from accelerator.
REQ-011 SHALL have port busy_o  output  1  accelerator job in flight.
REQ-012 SHALL have port irq_o  output  1  level interrupt to core.

Function
REQ-013 SHALL implement registers: 0x0 SCRATCH rw 32b; 0x4 CTRL (bit0 START write-1-pulse reads 0, bit1 IRQ_EN rw); 0x8 STATUS (bit0 BUSY ro, bit1 DONE sticky write-1-clear); 0xC CYCLES ro 32b.
REQ-014 SHALL decode hit when addr[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]; register index addr[3:2]; addr[1:0] ignored.
REQ-015 SHALL drive q_ready = !p_valid_q || p_ready; request accepted on q_valid && q_ready.
REQ-016 SHALL assert p_valid exactly one cycle after acceptance (1-cycle latency), one response per request, in order.
REQ-017 SHALL hold p.data and p.error stable while p_valid && !p_ready; accept-and-respond back-to-back when p_ready=1 (full throughput).
REQ-018 SHALL return read data sampled at acceptance cycle; write responses return data 0.
REQ-019 SHALL apply SCRATCH writes per byte strobe; CTRL/STATUS writes take effect only if strb[0]=1; writes to CYCLES ignored, no error.
REQ-020 SHALL respond error=1, data 0, no state change for: address miss, or amo != AMONone.
REQ-021 SHALL, on accepted CTRL write with data[0]=1 while BUSY=0, assert start_o for exactly the following cycle, set BUSY, clear CYCLES to 0 that cycle.
REQ-022 SHALL ignore START writes while BUSY=1 (no pulse, response error=0); IRQ_EN bit still updated.
REQ-023 SHALL increment CYCLES every cycle BUSY=1, wrapping 32'hFFFF_FFFF -> 0.
REQ-024 SHALL on done_i=1 while BUSY=1 clear BUSY and set DONE next cycle; done_i while BUSY=0 ignored.
REQ-025 SHALL give set priority when done_i sets DONE in the same cycle a W1C to DONE is accepted (DONE stays 1).
REQ-026 SHALL drive irq_o = DONE & IRQ_EN from registers (no combinational path from req_i); busy_o = BUSY.
REQ-027 SHALL allow start in the cycle after BUSY clears; START write same cycle as done_i sees BUSY=1 and is ignored.

Reset
REQ-028 SHALL on rst_ni=0 asynchronously clear all registers, p_valid=0, start_o=0, busy_o=0, irq_o=0; q_ready=1 from first cycle after reset release.
REQ-029 SHALL drop any pending response on reset mid-transaction; no response issued for it after release.

Verification
REQ-030 SHALL cover: write SCRATCH 0xDEADBEEF strb 4'b0101, then read -> 0x00AD00EF, error 0, p_valid 1 cycle after each accept.
REQ-031 SHALL cover: p_ready held 0 for 5 cycles after a read -> p_valid/data stable, q_ready=0, second request stalled until p_ready=1.
REQ-032 SHALL cover: write CTRL 0x3 -> start_o high exactly 1 cycle, busy_o=1; after 10 busy cycles done_i -> CYCLES reads 10, DONE=1, irq_o=1; W1C STATUS 0x2 -> irq_o=0.
REQ-033 SHALL cover: addr BaseAddr+0x10 and AMO to SCRATCH -> error 1, data 0, SCRATCH unchanged.
REQ-034 SHALL cover: done_i coincident with accepted W1C of DONE -> DONE remains 1; START during BUSY -> no start_o pulse.
REQ-035 SHALL cover: rst_ni asserted with p_valid=1 and BUSY=1 -> all outputs 0 immediately, no stale response after release.
